// File: rtl/delay_assign_sched.sv
// rtl/delay_assign_sched.sv - timed-write scheduler, serial (blocking) or concurrent (nonblocking) delays
module delay_assign_sched #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 6,
  parameter int DLY_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [$clog2(NUM_CH)-1:0]  req_ch_i,
  input  logic [WIDTH-1:0]           req_data_i,
  input  logic [DLY_W-1:0]           req_dly_i,
  output logic [NUM_CH*WIDTH-1:0]    q_o,
  output logic [NUM_CH-1:0]          upd_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CH_W:0]    NUM_CH_C = (CH_W+1)'(NUM_CH);

  logic [CH_W-1:0]  ch_q   [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DLY_W-1:0] tmr_q  [DEPTH];
  logic [CH_W-1:0]  ch_n   [DEPTH];
  logic [WIDTH-1:0] data_n [DEPTH];
  logic [DLY_W-1:0] tmr_n  [DEPTH];

  logic                    mode_q;
  logic                    mode_eff;
  logic                    elig;
  logic                    ch_ok;
  logic                    accept;
  logic                    bad_req;
  logic [NUM_CH*WIDTH-1:0] q_n;
  logic [NUM_CH-1:0]       upd_n;
  logic [CNT_W-1:0]        wr;

  assign req_ready_o = (count_o < DEPTH_C);
  assign busy_o      = (count_o != '0);

  always_comb begin
    mode_eff = (count_o == '0) ? mode_i : mode_q;
    ch_ok    = ({1'b0, req_ch_i} < NUM_CH_C);
    accept   = req_valid_i && req_ready_o && ch_ok;
    bad_req  = req_valid_i && req_ready_o && !ch_ok;
    q_n      = q_o;
    upd_n    = '0;
    wr       = '0;
    elig     = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      ch_n[j]   = '0;
      data_n[j] = '0;
      tmr_n[j]  = '0;
    end
    // Walk slots oldest first: later (younger) fires overwrite earlier ones on a shared channel.
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_o) begin
        elig = mode_eff || (i == 0);
        if (elig && (tmr_q[i] == '0)) begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q[i] == CH_W'(k)) begin
              q_n[k*WIDTH +: WIDTH] = data_q[i];
              upd_n[k]              = 1'b1;
            end
          end
        end else begin
          for (int j = 0; j < DEPTH; j++) begin
            if (wr == CNT_W'(j)) begin
              ch_n[j]   = ch_q[i];
              data_n[j] = data_q[i];
              tmr_n[j]  = elig ? (tmr_q[i] - DLY_W'(1)) : tmr_q[i];
            end
          end
          wr = wr + CNT_W'(1);
        end
      end
    end
    if (accept) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (wr == CNT_W'(j)) begin
          ch_n[j]   = req_ch_i;
          data_n[j] = req_data_i;
          tmr_n[j]  = req_dly_i;
        end
      end
      wr = wr + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= 1'b0;
      q_o     <= '0;
      upd_o   <= '0;
      count_o <= '0;
      err_o   <= 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        ch_q[j]   <= '0;
        data_q[j] <= '0;
        tmr_q[j]  <= '0;
      end
    end else begin
      mode_q  <= mode_eff;
      q_o     <= q_n;
      upd_o   <= upd_n;
      count_o <= wr;
      err_o   <= err_o | bad_req;
      for (int j = 0; j < DEPTH; j++) begin
        ch_q[j]   <= ch_n[j];
        data_q[j] <= data_n[j];
        tmr_q[j]  <= tmr_n[j];
      end
    end
  end

endmodule

// File: tb/tb_delay_assign_sched.sv
// tb/tb_delay_assign_sched.sv - scoreboard bench for delay_assign_sched
module tb_delay_assign_sched;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 6;
  localparam int DLY_W  = 8;
  localparam int DEPTH  = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    mode_i;
  logic                    req_valid_i;
  logic                    req_ready_o;
  logic [2:0]              req_ch_i;
  logic [WIDTH-1:0]        req_data_i;
  logic [DLY_W-1:0]        req_dly_i;
  logic [NUM_CH*WIDTH-1:0] q_o;
  logic [NUM_CH-1:0]       upd_o;
  logic [2:0]              count_o;
  logic                    busy_o;
  logic                    err_o;

  delay_assign_sched #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .DLY_W(DLY_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mode_i(mode_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_ch_i(req_ch_i), .req_data_i(req_data_i), .req_dly_i(req_dly_i), .q_o(q_o),
    .upd_o(upd_o), .count_o(count_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    int         ch;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t keep[$];
  int   npass = 0;
  int   nfail = 0;
  int   ntotal = 0;
  int   last_fire = 0;
  logic [NUM_CH-1:0] exp_mask;
  logic [7:0]        exp_val [NUM_CH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every edge, the entries due now define the exact upd_o mask and channel values.
  always @(negedge clk) begin
    if (!rst) begin
      exp_mask = '0;
      keep.delete();
      foreach (sb[n]) begin
        if (sb[n].at == cyc) begin
          exp_mask[sb[n].ch] = 1'b1;
          exp_val[sb[n].ch]  = sb[n].data;
        end else if (sb[n].at < cyc) begin
          chk("fire_edge", 64'(cyc), 64'(sb[n].at));
        end else begin
          keep.push_back(sb[n]);
        end
      end
      sb = keep;
      if (exp_mask != '0 || upd_o != '0) begin
        chk("upd_mask", 64'(upd_o), 64'(exp_mask));
        for (int c = 0; c < NUM_CH; c++)
          if (exp_mask[c]) chk("q_ch", 64'(q_o[c*WIDTH +: WIDTH]), 64'(exp_val[c]));
      end
    end
  end

  // Called just after a negedge; returns at the negedge following the accepting edge.
  task automatic send(input int ch, input logic [7:0] data, input int dly, input bit blk);
    bit   got = 0;
    logic r;
    int   acc;
    exp_t e;
    req_valid_i = 1'b1;
    req_ch_i    = 3'(ch);
    req_data_i  = data;
    req_dly_i   = 8'(dly);
    for (int t = 0; t < 50 && !got; t++) begin
      r = req_ready_o;
      @(negedge clk);
      if (r) got = 1;
    end
    req_valid_i = 1'b0;
    if (!got) chk("accept_timeout", 64'(got), 64'd1);
    else if (ch < NUM_CH) begin
      acc  = cyc;
      e.ch = ch;
      e.data = data;
      if (blk) begin
        e.at = ((acc > last_fire) ? acc : last_fire) + dly + 1;
        last_fire = e.at;
      end else begin
        e.at = acc + dly + 1;
      end
      sb.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int target);
    for (int t = 0; t < 300 && cyc < target; t++) @(negedge clk);
    chk("wait_cyc", 64'(cyc), 64'(target));
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 400; t++) begin
      if (count_o == '0 && sb.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("idle_count", 64'(count_o), 64'd0);
    chk("idle_sb", 64'(sb.size()), 64'd0);
  endtask

  int e0;
  int e5;

  initial begin
    rst = 1'b1; mode_i = 1'b0; req_valid_i = 1'b0;
    req_ch_i = '0; req_data_i = '0; req_dly_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_q", 64'(q_o), 64'd0);
    chk("rst_upd", 64'(upd_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_ready", 64'(req_ready_o), 64'd1);

    // Blocking: serial delays
    mode_i = 1'b0; last_fire = 0;
    send(0, 8'h01, 10, 1);
    e0 = cyc;
    send(1, 8'h00, 20, 1);
    send(2, 8'h01, 40, 1);
    chk("blk_count3", 64'(count_o), 64'd3);
    wait_cyc(e0 + 11); chk("blk_count2", 64'(count_o), 64'd2);
    wait_cyc(e0 + 32); chk("blk_count1", 64'(count_o), 64'd1);
    wait_cyc(e0 + 73); chk("blk_count0", 64'(count_o), 64'd0);
    wait_idle();

    // Nonblocking: concurrent delays
    mode_i = 1'b1;
    send(0, 8'h01, 10, 0);
    e0 = cyc;
    send(1, 8'h00, 20, 0);
    send(2, 8'h01, 40, 0);
    wait_cyc(e0 + 42); chk("nb_busy_hi", 64'(busy_o), 64'd1);
    wait_cyc(e0 + 43); chk("nb_busy_lo", 64'(busy_o), 64'd0);
    wait_idle();

    // Same-channel conflict: younger entry wins
    send(3, 8'hAA, 5, 0);
    e0 = cyc;
    send(3, 8'h55, 4, 0);
    wait_cyc(e0 + 7);
    chk("conf_q3", 64'(q_o[3*WIDTH +: WIDTH]), 64'h55);
    chk("conf_single_pulse", 64'(upd_o[3]), 64'd0);
    wait_idle();

    // Full engine backpressure
    for (int n = 0; n < 5; n++) begin
      send(n, 8'(8'h10 + n), 3, 0);
      if (n == 0) e0 = cyc;
      if (n == 3) chk("full_ready", 64'(req_ready_o), 64'd0);
      if (n == 4) e5 = cyc;
    end
    chk("fifth_accept_edge", 64'(e5 - e0), 64'd5);
    wait_idle();

    // Mode frozen while busy
    mode_i = 1'b1;
    send(0, 8'hC1, 8, 0);
    send(1, 8'hC2, 1, 0);
    mode_i = 1'b0;
    wait_idle();
    last_fire = 0;
    send(2, 8'hD1, 2, 1);
    send(3, 8'hD2, 2, 1);
    wait_idle();

    // Reset mid-run clears error, pending entries and outputs
    mode_i = 1'b1;
    send(7, 8'hEE, 1, 0);
    chk("err_set", 64'(err_o), 64'd1);
    chk("err_dropped", 64'(count_o), 64'd0);
    send(0, 8'h5A, 20, 0);
    e0 = cyc;
    send(1, 8'h5B, 20, 0);
    send(2, 8'h5C, 20, 0);
    wait_cyc(e0 + 5);
    rst = 1'b1;
    #1;
    chk("mid_rst_q", 64'(q_o), 64'd0);
    chk("mid_rst_count", 64'(count_o), 64'd0);
    chk("mid_rst_upd", 64'(upd_o), 64'd0);
    chk("mid_rst_err", 64'(err_o), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("post_rst_count", 64'(count_o), 64'd0);
    chk("post_rst_q", 64'(q_o), 64'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
